// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue
// Small FIFO between instruction fetch and decode. Holds {PC, instruction}
// pairs, presents the head entry to decode, and absorbs decode stalls and
// branch flushes without losing or duplicating instructions. Outputs are
// driven from registered state only, so there is no ready_i -> ready_o path
// and no same-cycle bypass from input to output.
module if_id_fetch_queue #(
    parameter int               DEPTH = 2,
    parameter int               XLEN  = 32,
    parameter int               PC_W  = 32,
    parameter logic [XLEN-1:0]  NOP   = 32'h00000013
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [PC_W-1:0]              in_pc_i,
    input  logic [XLEN-1:0]              in_instr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [PC_W-1:0]              out_pc_o,
    output logic [XLEN-1:0]              out_instr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; contents are only observed while counted valid.
    logic [PC_W-1:0]  r_mem_pc    [DEPTH];
    logic [XLEN-1:0]  r_mem_instr [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic             w_not_full;

    // Handshake qualification; flush suppresses both sides of the transfer.
    always_comb begin
        w_not_empty = (r_count != '0);
        w_not_full  = (r_count < CNT_W'(DEPTH));
        w_push      = in_valid_i & w_not_full & ~flush_i;
        w_pop       = w_not_empty & out_ready_i & ~flush_i;
    end

    assign in_ready_o  = w_not_full;
    assign out_valid_o = w_not_empty;
    assign count_o     = r_count;

    // Head presentation: stored entry while valid, zero PC / NOP while empty.
    always_comb begin
        out_pc_o    = '0;
        out_instr_o = NOP;
        if (w_not_empty) begin
            out_pc_o    = r_mem_pc[r_rd_ptr];
            out_instr_o = r_mem_instr[r_rd_ptr];
        end
    end

    // Pointer and occupancy state; flush rewinds both pointers to zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // One write port per entry, enabled when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_we;
            assign w_we = w_push && (r_wr_ptr == PTR_W'(gi));

            // Capture the offered pair into this entry on an accepted push.
            always_ff @(posedge clk_i) begin
                if (w_we) begin
                    r_mem_pc[gi]    <= in_pc_i;
                    r_mem_instr[gi] <= in_instr_i;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed testbench for if_id_fetch_queue (DEPTH=2). Inputs change and
// outputs are sampled 1ns after the rising edge.
module tb_if_id_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_pc_i = '0;
    logic [31:0] in_instr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic [1:0]  count_o;

    int n_pass  = 0;
    int n_total = 0;

    if_id_fetch_queue #(.DEPTH(2), .XLEN(32), .PC_W(32), .NOP(NOP)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pc_i     (in_pc_i),
        .in_instr_i  (in_instr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_instr_o (out_instr_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [1:0] cnt);
        chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd1);
        chk({tag, ".pc"},    out_pc_o,    pc);
        chk({tag, ".instr"}, out_instr_o, instr);
        chk({tag, ".count"}, {30'd0, count_o}, {30'd0, cnt});
        $display("%s: head pc=%h instr=%h count=%0d", tag, out_pc_o, out_instr_o, count_o);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd0);
        chk({tag, ".pc"},    out_pc_o,    32'd0);
        chk({tag, ".instr"}, out_instr_o, NOP);
        chk({tag, ".count"}, {30'd0, count_o}, 32'd0);
        chk({tag, ".ready"}, {31'd0, in_ready_o}, 32'd1);
        $display("%s: empty pc=%h instr=%h count=%0d", tag, out_pc_o, out_instr_o, count_o);
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid_i = v;
        in_pc_i    = pc;
        in_instr_i = instr;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk_empty("por");
        tick();
        rst_i = 1'b1;
        tick();
        chk_empty("por_release");

        // Pass-through
        out_ready_i = 1'b1;
        offer(1'b1, 32'h0, 32'h00500093);
        tick();
        chk_head("pass", 32'h0, 32'h00500093, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("pass_drain");

        // Fill to full while decode stalls, third offer held
        out_ready_i = 1'b0;
        offer(1'b1, 32'h0, 32'h10000000);
        tick();
        chk_head("fill0", 32'h0, 32'h10000000, 2'd1);
        offer(1'b1, 32'h4, 32'h10000004);
        tick();
        chk_head("fill1", 32'h0, 32'h10000000, 2'd2);
        chk("fill1.ready", {31'd0, in_ready_o}, 32'd0);
        offer(1'b1, 32'h8, 32'h10000008);
        tick();
        chk_head("full_hold", 32'h0, 32'h10000000, 2'd2);
        chk("full_hold.ready", {31'd0, in_ready_o}, 32'd0);
        out_ready_i = 1'b1;
        tick();
        chk_head("rel0", 32'h4, 32'h10000004, 2'd1);
        tick();
        chk_head("rel1", 32'h8, 32'h10000008, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("rel_drain");

        // Streaming push+pop at count=1, pointers wrap repeatedly
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
            chk_head($sformatf("stream%0d", i), 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd1);
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("stream_drain");

        // Flush at count=2 with a same-cycle push and out_ready
        out_ready_i = 1'b0;
        offer(1'b1, 32'h50, 32'h50505050);
        tick();
        offer(1'b1, 32'h54, 32'h54545454);
        tick();
        chk_head("pre_flush", 32'h50, 32'h50505050, 2'd2);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        offer(1'b1, 32'h40, 32'h40404040);
        tick();
        chk_empty("flush_full");
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        offer(1'b1, 32'h80, 32'h80808080);
        tick();
        chk_head("post_flush", 32'h80, 32'h80808080, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        tick();
        chk_empty("post_flush_drain");

        // Flush at count=1 while in_ready is high: push still dropped
        out_ready_i = 1'b0;
        offer(1'b1, 32'h60, 32'h60606060);
        tick();
        flush_i = 1'b1;
        offer(1'b1, 32'h64, 32'h64646464);
        tick();
        chk_empty("flush_ready");
        flush_i = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("flush_ready_idle");

        // Stall hold: head stable for 5 cycles under continued pushes
        offer(1'b1, 32'h4, 32'hFE000EE3);
        tick();
        chk_head("stall_load", 32'h4, 32'hFE000EE3, 2'd1);
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 32'h8 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            tick();
            chk_head($sformatf("stall%0d", i), 32'h4, 32'hFE000EE3, 2'd2);
        end
        out_ready_i = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk_head("stall_rel", 32'h8, 32'hB000_0000, 2'd1);
        out_ready_i = 1'b0;

        // Asynchronous reset mid-stream with count=2
        offer(1'b1, 32'h90, 32'h90909090);
        tick();
        chk_head("pre_rst", 32'h8, 32'hB000_0000, 2'd2);
        offer(1'b0, 32'h0, 32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        chk_empty("async_rst");
        tick();
        chk_empty("rst_held");
        #2;
        rst_i = 1'b1;
        tick();
        offer(1'b1, 32'hC0, 32'hC0C0C0C0);
        tick();
        chk_head("after_rst", 32'hC0, 32'hC0C0C0C0, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b1;
        tick();
        chk_empty("after_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
